// File: rtl/matrix_stream_serializer.sv
// Serializes a packed ROWS x COLS matrix into beats of LANES elements over a valid/ready stream.
// Optional macro MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN enables column-major traversal selected by in_order.
module matrix_stream_serializer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int LANES     = 1,
    localparam int ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ROWS*COLS*BIT_WIDTH-1:0] in_data,
    input  logic                          in_order,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*BIT_WIDTH-1:0]    out_data,
    output logic                          out_first,
    output logic                          out_last,
    output logic [ROW_W-1:0]              out_row,
    output logic [COL_W-1:0]              out_col
);

    localparam int MAT_W  = ROWS * COLS * BIT_WIDTH;
    localparam int IDX_W  = (MAT_W > 1) ? $clog2(MAT_W) : 1;
    localparam int BEATS  = (ROWS * COLS) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAT_W-1:0]   mat;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;
    logic [BEAT_W-1:0]  beat;
    logic [ROW_W-1:0]   row_step;
    logic [COL_W-1:0]   col_step;
    logic               accept;
    logic               fire;
    logic               last_beat;

`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
    logic               col_major;
`else
    logic               unused_in_order;
    assign unused_in_order = in_order;
`endif

    // Handshake: a finishing matrix frees the input in the same cycle for zero-bubble chaining.
    assign out_valid = (state == STREAM);
    assign last_beat = (beat == LAST_BEAT);
    assign fire      = out_valid && out_ready;
    assign in_ready  = rst_n && ((state == IDLE) || (fire && last_beat));
    assign accept    = in_valid && in_ready;

    assign out_first = out_valid && (beat == '0);
    assign out_last  = out_valid && last_beat;
    assign out_row   = row;
    assign out_col   = col;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (fire && last_beat && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next lane-0 coordinates; row-major is the default walk, column-major overrides it.
    always_comb begin
        row_step = row;
        col_step = col;
        if (int'(col) + LANES >= COLS) begin
            col_step = '0;
            row_step = (row == ROW_MAX) ? '0 : row + ROW_W'(1);
        end else begin
            col_step = col + COL_W'(LANES);
        end
`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
        if (col_major) begin
            if (int'(row) + LANES >= ROWS) begin
                row_step = '0;
                col_step = (col == COL_MAX) ? '0 : col + COL_W'(1);
            end else begin
                row_step = row + ROW_W'(LANES);
                col_step = col;
            end
        end
`endif
    end

    // NOTE: the held matrix is cleared on reset so out_data reads 0 until a new matrix arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mat       <= '0;
            row       <= '0;
            col       <= '0;
            beat      <= '0;
`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
            col_major <= 1'b0;
`endif
        end else if (accept) begin
            mat       <= in_data;
            row       <= '0;
            col       <= '0;
            beat      <= '0;
`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
            col_major <= in_order;
`endif
        end else if (fire) begin
            row  <= row_step;
            col  <= col_step;
            beat <= last_beat ? '0 : beat + BEAT_W'(1);
        end
    end

    // Element (r,c) lives at flat index c*ROWS+r; lanes walk along the current traversal axis.
    always_comb begin : lane_mux
        int               elem;
        logic [IDX_W-1:0] lsb;
        out_data = '0;
        for (int l = 0; l < LANES; l++) begin
            elem = (int'(col) + l) * ROWS + int'(row);
`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
            if (col_major) begin
                elem = int'(col) * ROWS + int'(row) + l;
            end
`endif
            lsb = IDX_W'(elem * BIT_WIDTH);
            out_data[l*BIT_WIDTH +: BIT_WIDTH] = mat[lsb +: BIT_WIDTH];
        end
    end

endmodule

// File: tb/tb_matrix_stream_serializer.sv
// Self-checking bench for matrix_stream_serializer: directed table on a 2x3 instance plus
// randomized traffic on a 2x3/1-lane and a 4x4/2-lane instance checked against a beat-list model.
module tb_matrix_stream_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_v [2];
    logic        in_order_v [2];
    logic        out_ready_v[2];
    logic [23:0] a_in_data;
    logic [63:0] b_in_data;

    logic        a_in_ready, a_out_valid, a_out_first, a_out_last;
    logic [3:0]  a_out_data;
    logic [0:0]  a_out_row;
    logic [1:0]  a_out_col;
    logic        b_in_ready, b_out_valid, b_out_first, b_out_last;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_row;
    logic [1:0]  b_out_col;

    matrix_stream_serializer #(.BIT_WIDTH(4), .ROWS(2), .COLS(3), .LANES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(a_in_ready), .in_data(a_in_data), .in_order(in_order_v[0]),
        .out_valid(a_out_valid), .out_ready(out_ready_v[0]), .out_data(a_out_data),
        .out_first(a_out_first), .out_last(a_out_last), .out_row(a_out_row), .out_col(a_out_col)
    );

    matrix_stream_serializer #(.BIT_WIDTH(4), .ROWS(4), .COLS(4), .LANES(2)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(b_in_ready), .in_data(b_in_data), .in_order(in_order_v[1]),
        .out_valid(b_out_valid), .out_ready(out_ready_v[1]), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last), .out_row(b_out_row), .out_col(b_out_col)
    );

    logic       in_ready_v[2], out_valid_v[2], first_v[2], last_v[2];
    logic [7:0] od[2];
    logic [1:0] orow[2], ocol[2];
    assign in_ready_v[0] = a_in_ready;   assign in_ready_v[1] = b_in_ready;
    assign out_valid_v[0] = a_out_valid; assign out_valid_v[1] = b_out_valid;
    assign first_v[0] = a_out_first;     assign first_v[1] = b_out_first;
    assign last_v[0] = a_out_last;       assign last_v[1] = b_out_last;
    assign od[0] = {4'b0, a_out_data};   assign od[1] = b_out_data;
    assign orow[0] = {1'b0, a_out_row};  assign orow[1] = b_out_row;
    assign ocol[0] = a_out_col;          assign ocol[1] = b_out_col;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] data;
        int         row;
        int         col;
        bit         first;
        bit         last;
    } beat_t;

    logic [3:0] mat_g[2][4][4];
    beat_t      q0[$];
    beat_t      q1[$];

    function automatic int n_rows(input int inst);  return (inst == 0) ? 2 : 4; endfunction
    function automatic int n_cols(input int inst);  return (inst == 0) ? 3 : 4; endfunction
    function automatic int n_lanes(input int inst); return (inst == 0) ? 1 : 2; endfunction

    function automatic int q_size(input int inst);
        return (inst == 0) ? q0.size() : q1.size();
    endfunction

    function automatic beat_t q_front(input int inst);
        return (inst == 0) ? q0[0] : q1[0];
    endfunction

    task automatic q_pop(input int inst);
        if (inst == 0) void'(q0.pop_front());
        else           void'(q1.pop_front());
    endtask

    task automatic q_push(input int inst, input beat_t b);
        if (inst == 0) q0.push_back(b);
        else           q1.push_back(b);
    endtask

    function automatic logic [63:0] pack_mat(input int inst);
        logic [63:0] v = '0;
        for (int r = 0; r < n_rows(inst); r++)
            for (int c = 0; c < n_cols(inst); c++)
                v[(c*n_rows(inst)+r)*4 +: 4] = mat_g[inst][r][c];
        return v;
    endfunction

    task automatic set_in_data(input int inst);
        logic [63:0] v;
        v = pack_mat(inst);
        if (inst == 0) a_in_data = v[23:0];
        else           b_in_data = v;
    endtask

    // Expands the currently offered matrix into its full expected beat list.
    task automatic model_push(input int inst, input bit ord);
        int    nr, nc, ln, nb, k;
        bit    cm;
        beat_t b;
        nr = n_rows(inst); nc = n_cols(inst); ln = n_lanes(inst);
        nb = nr * nc / ln;
        k  = 0;
        cm = ord;
`ifndef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
        cm = 1'b0;
`endif
        if (!cm) begin
            for (int r = 0; r < nr; r++)
                for (int c = 0; c < nc; c += ln) begin
                    b.data = '0;
                    for (int l = 0; l < ln; l++) b.data[l*4 +: 4] = mat_g[inst][r][c+l];
                    b.row = r; b.col = c; b.first = (k == 0); b.last = (k == nb - 1);
                    q_push(inst, b);
                    k++;
                end
        end else begin
            for (int c = 0; c < nc; c++)
                for (int r = 0; r < nr; r += ln) begin
                    b.data = '0;
                    for (int l = 0; l < ln; l++) b.data[l*4 +: 4] = mat_g[inst][r+l][c];
                    b.row = r; b.col = c; b.first = (k == 0); b.last = (k == nb - 1);
                    q_push(inst, b);
                    k++;
                end
        end
    endtask

    // Instance 0 gets element (r,c) = 3r+c+offs.
    task automatic load_a(input int offs);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                mat_g[0][r][c] = 4'(3*r + c + offs);
        set_in_data(0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit         offer;
        bit         ord;
        bit         rdy;
        bit         e_in_ready;
        bit         e_valid;
        logic [3:0] e_data;
        int         e_row;
        int         e_col;
        bit         e_first;
        bit         e_last;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit offer, input bit ord, input bit rdy, input bit eir, input bit ev,
                       input int d, input int r, input int c, input bit f, input bit l);
        vec_t v;
        v.offer = offer; v.ord = ord; v.rdy = rdy; v.e_in_ready = eir; v.e_valid = ev;
        v.e_data = 4'(d); v.e_row = r; v.e_col = c; v.e_first = f; v.e_last = l;
        tbl.push_back(v);
    endtask

    task automatic add_offer(input bit ord);
        add(1'b1, ord, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic add_idle();
        add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic add_beat(input bit rdy, input int r, input int c, input bit f, input bit l);
        add(1'b0, 1'b0, rdy, l && rdy, 1'b1, 3*r + c, r, c, f, l);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_after_reset(input int inst, input string tag);
        check({tag, " in_ready"},  in_ready_v[inst], 1'b1);
        check({tag, " out_valid"}, out_valid_v[inst], 1'b0);
        check({tag, " out_data"},  od[inst], 0);
        check({tag, " out_first"}, first_v[inst], 1'b0);
        check({tag, " out_last"},  last_v[inst], 1'b0);
        check({tag, " out_row"},   orow[inst], 0);
        check({tag, " out_col"},   ocol[inst], 0);
    endtask

    // One randomized cycle on both instances; drain mode stops offers and always accepts beats.
    task automatic rand_cycle(input bit drain);
        bit    exp_ir;
        bit    was_valid;
        beat_t h;
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i]  = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
            out_ready_v[i] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_order_v[i]  = 1'($urandom_range(0, 1));
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    mat_g[i][r][c] = 4'($urandom_range(0, 15));
            set_in_data(i);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            was_valid = (q_size(i) != 0);
            exp_ir    = (q_size(i) == 0) || (q_size(i) == 1 && out_ready_v[i]);
            check($sformatf("rand%0d in_ready", i), in_ready_v[i], exp_ir);
            check($sformatf("rand%0d out_valid", i), out_valid_v[i], was_valid);
            if (was_valid) begin
                h = q_front(i);
                check($sformatf("rand%0d out_data", i),  od[i], h.data);
                check($sformatf("rand%0d out_row", i),   orow[i], h.row);
                check($sformatf("rand%0d out_col", i),   ocol[i], h.col);
                check($sformatf("rand%0d out_first", i), first_v[i], h.first);
                check($sformatf("rand%0d out_last", i),  last_v[i], h.last);
                if (out_ready_v[i]) q_pop(i);
            end
            if (in_valid_v[i] && exp_ir) model_push(i, in_order_v[i]);
        end
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i] = 1'b0; in_order_v[i] = 1'b0; out_ready_v[i] = 1'b1;
        end
        a_in_data = '0;
        b_in_data = '0;

        // Reset state
        tick();
        check("reset a in_ready low", a_in_ready, 1'b0);
        check("reset b in_ready low", b_in_ready, 1'b0);
        check("reset a out_valid", a_out_valid, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_idle_after_reset(0, "post-reset a");
        check_idle_after_reset(1, "post-reset b");

        // Table: plain stream, stalled stream, order-1 stream
        for (int k = 0; k < 6; k++) begin
            if (k == 0) add_offer(1'b0);
            add_beat(1'b1, k / 3, k % 3, k == 0, k == 5);
        end
        add_idle();
        add_offer(1'b0);
        add_beat(1'b1, 0, 0, 1'b1, 1'b0);
        add_beat(1'b1, 0, 1, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) add_beat(1'b0, 0, 2, 1'b0, 1'b0);
        add_beat(1'b1, 0, 2, 1'b0, 1'b0);
        for (int k = 3; k < 6; k++) add_beat(1'b1, k / 3, k % 3, 1'b0, k == 5);
        add_idle();
        add_offer(1'b1);
        for (int k = 0; k < 6; k++) begin
`ifdef MATRIX_STREAM_SERIALIZER_COL_MAJOR_EN
            add_beat(1'b1, k % 2, k / 2, k == 0, k == 5);
`else
            add_beat(1'b1, k / 3, k % 3, k == 0, k == 5);
`endif
        end
        add_idle();

        foreach (tbl[i]) begin
            in_valid_v[0]  = tbl[i].offer;
            out_ready_v[0] = tbl[i].rdy;
            if (tbl[i].offer) begin
                load_a(0);
                in_order_v[0] = tbl[i].ord;
            end else begin
                a_in_data     = 24'($urandom);
                in_order_v[0] = 1'($urandom_range(0, 1));
            end
            #1;
            check($sformatf("vec%0d in_ready", i), a_in_ready, tbl[i].e_in_ready);
            check($sformatf("vec%0d out_valid", i), a_out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d out_data", i),  a_out_data, tbl[i].e_data);
                check($sformatf("vec%0d out_row", i),   a_out_row, tbl[i].e_row);
                check($sformatf("vec%0d out_col", i),   a_out_col, tbl[i].e_col);
                check($sformatf("vec%0d out_first", i), a_out_first, tbl[i].e_first);
                check($sformatf("vec%0d out_last", i),  a_out_last, tbl[i].e_last);
            end
            tick();
        end

        // Back-to-back matrices: second one held on the input until taken in the out_last cycle
        in_valid_v[0] = 1'b1; in_order_v[0] = 1'b0; out_ready_v[0] = 1'b1;
        load_a(0);
        #1;
        check("b2b first accept in_ready", a_in_ready, 1'b1);
        tick();
        for (int k = 0; k < 12; k++) begin
            in_valid_v[0] = (k < 6);
            load_a((k < 6) ? 8 : 0);
            #1;
            check($sformatf("b2b%0d out_valid", k), a_out_valid, 1'b1);
            check($sformatf("b2b%0d out_data", k),  a_out_data, (k < 6) ? k : k + 2);
            check($sformatf("b2b%0d out_first", k), a_out_first, (k == 0) || (k == 6));
            check($sformatf("b2b%0d out_last", k),  a_out_last, (k == 5) || (k == 11));
            if (k < 6) check($sformatf("b2b%0d in_ready", k), a_in_ready, k == 5);
            tick();
        end
        in_valid_v[0] = 1'b0;
        #1;
        check("b2b drained out_valid", a_out_valid, 1'b0);
        tick();

        // Reset in the middle of a matrix, then a fresh matrix
        in_valid_v[0] = 1'b1;
        load_a(0);
        tick();
        in_valid_v[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rst-pre beat%0d out_data", k), a_out_data, k);
            tick();
        end
        rst_n = 1'b0;
        #1;
        check("rst in_ready low", a_in_ready, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
        check_idle_after_reset(0, "mid-stream reset");
        in_valid_v[0] = 1'b1;
        load_a(0);
        tick();
        in_valid_v[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rst-post beat%0d out_data", k), a_out_data, k);
            check($sformatf("rst-post beat%0d out_first", k), a_out_first, k == 0);
            tick();
        end
        #1;
        check("rst-post idle out_valid", a_out_valid, 1'b0);

        // Randomized traffic against the model, then drain
        for (int cyc = 0; cyc < 1500; cyc++) rand_cycle(1'b0);
        for (int cyc = 0; cyc < 12; cyc++) rand_cycle(1'b1);
        check("rand0 model drained", q_size(0), 0);
        check("rand1 model drained", q_size(1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
